// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared constants and the lane popcount used by the optional carry statistics.
// Contents: HA_MAX_WIDTH (widest supported lane count), STATS_W (carry counter width), popcount_w().
package half_adder_pkg;
   localparam int HA_MAX_WIDTH = 64;
   localparam int STATS_W = 32;
   function automatic logic [STATS_W-1:0] popcount_w(input logic [HA_MAX_WIDTH-1:0] v);
      popcount_w = '0;
      for (int i = 0; i < HA_MAX_WIDTH; i++) popcount_w = popcount_w + STATS_W'(v[i]);
   endfunction
endpackage

// File: rtl/half_adder_bit.sv
// half_adder_bit: single-lane combinational half adder.
// Ports: x, y operand bits in; C = x & y carry out; S = x ^ y sum out.
module half_adder_bit (
   input  logic x,
   input  logic y,
   output logic C,
   output logic S
);
   assign C = x & y;
   assign S = x ^ y;
endmodule

// File: rtl/half_adder.sv
// half_adder: WIDTH independent half-adder lanes with combinational and registered outputs.
// Ports: clk, rst (async active-high); x, y operands; C, S combinational carry/sum;
//        in_valid qualifies capture; c_q, s_q registered carry/sum; out_valid marks a fresh capture.
// Build option HALF_ADDER_STATS_EN adds stats_clr (sync clear) and carry_count (saturating count
// of carry bits seen on valid cycles).
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
`ifdef HALF_ADDER_STATS_EN
   input  logic             stats_clr,
   output logic [STATS_W-1:0] carry_count,
`endif
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             in_valid,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] c_q,
   output logic [WIDTH-1:0] s_q,
   output logic             out_valid
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_bit u_bit (
         .x(x[i]),
         .y(y[i]),
         .C(C[i]),
         .S(S[i])
      );
   end

   // Registered results hold across idle cycles; only out_valid tracks in_valid every edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q       <= '0;
         s_q       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            c_q <= C;
            s_q <= S;
         end
      end
   end

`ifdef HALF_ADDER_STATS_EN
   // One extra bit of headroom exposes overflow so the counter can stick at all-ones.
   logic [STATS_W:0] cnt_sum;
   assign cnt_sum = {1'b0, carry_count} + {1'b0, popcount_w(HA_MAX_WIDTH'(C))};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) carry_count <= '0;
      else if (stats_clr) carry_count <= '0;
      else if (in_valid) carry_count <= cnt_sum[STATS_W] ? '1 : cnt_sum[STATS_W-1:0];
   end
`endif
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: randomized self-checking bench against a lane-arithmetic reference model.
module tb_half_adder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        stats_clr = 1'b0;
   logic [0:0]  x1 = '0, y1 = '0;
   logic [0:0]  c1, s1, cq1, sq1;
   logic        ov1;
   logic [15:0] x = '0, y = '0;
   logic [15:0] c, s, c_q, s_q;
   logic        out_valid;
   logic [31:0] carry_count, cc1;

   logic [15:0] e_cq, e_sq;
   logic        e_ov, e_cq1, e_sq1, e_ov1;
   longint      e_cnt;
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   half_adder #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst),
`ifdef HALF_ADDER_STATS_EN
      .stats_clr(stats_clr), .carry_count(cc1),
`endif
      .x(x1), .y(y1), .in_valid(in_valid),
      .C(c1), .S(s1), .c_q(cq1), .s_q(sq1), .out_valid(ov1)
   );

   half_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
`ifdef HALF_ADDER_STATS_EN
      .stats_clr(stats_clr), .carry_count(carry_count),
`endif
      .x(x), .y(y), .in_valid(in_valid),
      .C(c), .S(s), .c_q(c_q), .s_q(s_q), .out_valid(out_valid)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Each lane adds two one-bit numbers; carry is the twos digit, sum the ones digit.
   task automatic ref_ha(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] co, output logic [15:0] so, output int ncarry);
      ncarry = 0;
      for (int i = 0; i < 16; i++) begin
         int t = int'(a[i]) + int'(b[i]);
         co[i] = (t / 2) == 1;
         so[i] = (t % 2) == 1;
         ncarry += t / 2;
      end
   endtask

   task automatic reset_model();
      e_cq = '0; e_sq = '0; e_ov = 1'b0;
      e_cq1 = 1'b0; e_sq1 = 1'b0; e_ov1 = 1'b0;
      e_cnt = 0;
   endtask

   task automatic check_comb(input string tag);
      logic [15:0] ec, es;
      int n;
      ref_ha(x, y, ec, es, n);
      check({tag, "_C"}, 64'(c), 64'(ec));
      check({tag, "_S"}, 64'(s), 64'(es));
      check({tag, "_CandS"}, 64'(c & s), 64'(0));
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_c_q"}, 64'(c_q), 64'(e_cq));
      check({tag, "_s_q"}, 64'(s_q), 64'(e_sq));
      check({tag, "_ov"}, 64'(out_valid), 64'(e_ov));
      check({tag, "_cq1"}, 64'(cq1), 64'(e_cq1));
      check({tag, "_sq1"}, 64'(sq1), 64'(e_sq1));
      check({tag, "_ov1"}, 64'(ov1), 64'(e_ov1));
`ifdef HALF_ADDER_STATS_EN
      check({tag, "_cnt"}, 64'(carry_count), 64'(e_cnt));
`endif
   endtask

   // Inputs are stable across the edge; the model is advanced with the values the DUT saw.
   task automatic tick();
      logic [15:0] ec, es, ec1, es1;
      int n, n1;
      ref_ha(x, y, ec, es, n);
      ref_ha(16'(x1), 16'(y1), ec1, es1, n1);
      @(posedge clk);
      e_ov = in_valid;
      e_ov1 = in_valid;
      if (in_valid) begin
         e_cq = ec; e_sq = es;
         e_cq1 = ec1[0]; e_sq1 = es1[0];
      end
      if (stats_clr) e_cnt = 0;
      else if (in_valid) e_cnt = (e_cnt + n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_cnt + n;
      #1;
   endtask

   initial begin
      logic [1:0] exp_cs [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
      reset_model();
      #3;
      check_regs("rst_async");
      @(posedge clk); @(posedge clk); #1;
      check_regs("rst_hold");
      rst = 1'b0;
      tick();
      check_regs("post_rst_idle");

      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = 2'(i);
         x1 = ab[1]; y1 = ab[0];
         #10;
         check($sformatf("tt%0d_C", i), 64'(c1), 64'(exp_cs[i][1]));
         check($sformatf("tt%0d_S", i), 64'(s1), 64'(exp_cs[i][0]));
      end

      x1 = 1'b1; y1 = 1'b1; in_valid = 1'b1;
      tick();
      check("w1_cq", 64'(cq1), 64'(1));
      check("w1_sq", 64'(sq1), 64'(0));
      check("w1_ov", 64'(ov1), 64'(1));
      in_valid = 1'b0; x1 = 1'b0;
      tick();
      check("w1_hold_cq", 64'(cq1), 64'(1));
      check("w1_hold_ov", 64'(ov1), 64'(0));
      check_regs("w1_hold");

      x = 16'h00F0; y = 16'h00CC;
      #1;
      check("w8_C", 64'(c), 64'h00C0);
      check("w8_S", 64'(s), 64'h003C);
      in_valid = 1'b1;
      tick();
      check("w8_cq", 64'(c_q), 64'h00C0);
      check("w8_sq", 64'(s_q), 64'h003C);
      check_regs("w8");

      @(negedge clk);
      rst = 1'b1;
      #1;
      reset_model();
      check_regs("mid_rst");
      check("mid_rst_C", 64'(c), 64'h00C0);
      check("mid_rst_S", 64'(s), 64'h003C);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      tick();
      check_regs("after_rst_idle");
      in_valid = 1'b1;
      tick();
      check_regs("after_rst_cap");

`ifdef HALF_ADDER_STATS_EN
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      check("stats_clr0", 64'(carry_count), 64'(0));
      x = 16'h000F; y = 16'h000F; in_valid = 1'b1;
      repeat (3) tick();
      check("stats_12", 64'(carry_count), 64'(12));
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      check("stats_clr_prio", 64'(carry_count), 64'(0));
      check_regs("stats");
`endif

      for (int i = 0; i < 1000; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         stats_clr = ($urandom_range(0, 49) == 0);
         x1 = 1'($urandom);
         y1 = 1'($urandom);
         #1;
         check_comb("rnd");
         tick();
         check_regs("rnd");
      end
      stats_clr = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bit-parallel half adder: WIDTH independent lanes, each computing S = x XOR y and C = x AND y.
- Provides combinational results plus a registered copy with a valid flag for pipelined datapaths.
- Used as a leaf arithmetic cell inside adder/counter structures and as a training/verification primitive.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  asynchronous, active-high reset.
- x  input  WIDTH  operand A, one bit per lane.
- y  input  WIDTH  operand B, one bit per lane.
- C  output  WIDTH  combinational carry, C[i] = x[i] & y[i].
- S  output  WIDTH  combinational sum, S[i] = x[i] ^ y[i].
- in_valid  input  1  qualifies x/y for the registered path.
- c_q  output  WIDTH  registered carry.
- s_q  output  WIDTH  registered sum.
- out_valid  output  1  c_q/s_q hold a result captured from a valid input.

Behaviour:
- One clock; rst is asynchronous and active-high.
- Combinational path: C and S depend only on x and y, with zero latency and no dependence on clk, rst or in_valid. Truth table per lane:
  - 0,0 -> C=0,S=0
  - 0,1 -> C=0,S=1
  - 1,0 -> C=0,S=1
  - 1,1 -> C=1,S=0
- Lanes are fully independent; there is no carry propagation between lanes.
- Registered path, latency 1:
  - On a rising clk with in_valid=1: c_q<=C, s_q<=S, out_valid<=1.
  - On a rising clk with in_valid=0: c_q and s_q hold their values; out_valid<=0.
- Reset: asserting rst immediately forces c_q=0, s_q=0 and out_valid=0, regardless of clk. Combinational C/S keep tracking x/y during reset.
- Reset mid-operation: a pending capture is discarded. The first capture after rst deasserts happens on the first rising edge with in_valid=1.
- X/Z on inputs propagates per standard Verilog semantics; no input sanitising.
- Invariant: for every lane, C and S are never both 1. Same for c_q and s_q.

Optional Feature:
- Macro HALF_ADDER_STATS_EN.
- When defined:
  - Adds output carry_count (32 bits) and input stats_clr (1 bit).
  - On each rising clk with in_valid=1, carry_count increments by popcount(C).
  - Counter saturates at 0xFFFF_FFFF; no wrap.
  - stats_clr=1 zeroes the counter synchronously and takes priority over increment.
  - rst zeroes the counter asynchronously.
- When undefined: those ports and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package half_adder_pkg holds:
  - HA_MAX_WIDTH = 64.
  - STATS_W = 32.
  - Function popcount_w for the stats option.
- Sub-module half_adder_bit: 1-bit purely combinational cell (x, y -> C, S). Instantiated WIDTH times via generate.
- The top level adds the output registers, valid flag and optional stats.

Test Plan:
- WIDTH=1, apply x/y = 00,01,10,11 for 10 ns each -> C/S = 0/0, 0/1, 0/1, 1/0, settled combinationally within each step.
- WIDTH=1, in_valid=1, x=1,y=1 sampled at an edge -> next cycle c_q=1, s_q=0, out_valid=1. Then in_valid=0 -> c_q/s_q hold, out_valid=0.
- WIDTH=8, x=8'hF0, y=8'hCC -> C=8'hC0, S=8'h3C. Registered copy appears one cycle later.
- Assert rst between clock edges while out_valid=1 -> c_q, s_q, out_valid drop to 0 immediately. C/S still reflect x/y.
- Exhaustive random over 1000 cycles with WIDTH=16 -> C==x&y, S==x^y, and never C&S nonzero.
- With HALF_ADDER_STATS_EN, WIDTH=4, three valid cycles of x=y=4'hF -> carry_count=12. stats_clr -> 0 on the next edge.
